// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/issue/execute sequencer that owns the program counter.
// Optional statistics counters are built when PC_SEQ_STATS_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | out of reset, waiting for start
// FETCH | imem_req held with imem_addr = pc until imem_ack
// ISSUE | instr newly latched, instr_valid pulses for this one cycle
// EXEC  | waiting for exec_done, then halt, fault or load br_next_pc
// HALT  | stopped on halt or misaligned target; start restarts
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              halt_req,
    input  logic [31:0]       br_next_pc,
    input  logic              br_take,
    input  logic              br_jump,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              halted,
    output logic              fault
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] jump_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_req;
    logic        r_valid;
    logic        r_busy;
    logic        r_halted;
    logic        r_fault;
    logic        w_misaligned;
    logic        w_advance;

    assign w_misaligned = (br_next_pc[1:0] != 2'b00);
    // Only a retiring, non-halt, aligned instruction moves the pc and the stats.
    assign w_advance    = (r_state == S_EXEC) && exec_done && !halt_req && !w_misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= 32'h0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state  <= S_FETCH;
                        r_pc     <= RESET_PC;
                        r_fault  <= 1'b0;
                        r_req    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_ISSUE;
                        r_instr <= imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_EXEC;
                    r_valid <= 1'b0;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (halt_req || w_misaligned) begin
                            r_state  <= S_HALT;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_fault  <= !halt_req;
                        end else begin
                            r_state <= S_FETCH;
                            r_pc    <= br_next_pc;
                            r_req   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_req    <= 1'b0;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign imem_req    = r_req;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign fault       = r_fault;

`ifdef PC_SEQ_STATS_EN
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_jump_cnt;
    logic              w_restart;

    assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_jump_cnt   <= '0;
        end else if (w_restart) begin
            r_branch_cnt <= '0;
            r_jump_cnt   <= '0;
        end else if (w_advance) begin
            if (br_take && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (br_jump && (r_jump_cnt != '1))
                r_jump_cnt <= r_jump_cnt + 1'b1;
        end
    end

    assign branch_count = r_branch_cnt;
    assign jump_count   = r_jump_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{br_take, br_jump, w_advance};
`endif

endmodule
